// File: rtl/dsp_pipe_pkg.sv
// Shared constants and helpers for the tapped delay pipeline: legal parameter
// ranges and the tap-select width derivation.
package dsp_pipe_pkg;

  localparam int DATA_WIDTH_MIN  = 1;
  localparam int DATA_WIDTH_MAX  = 48;
  localparam int DEPTH_MIN       = 1;
  localparam int DEPTH_MAX       = 8;
  localparam int DEFAULT_TAP_MIN = 0;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Tap values run 0..DEPTH inclusive, hence DEPTH+1 codes.
  function automatic int tap_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int data_width, input int depth,
                                      input int default_tap);
    return (data_width >= DATA_WIDTH_MIN) && (data_width <= DATA_WIDTH_MAX) &&
           (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
           (default_tap >= DEFAULT_TAP_MIN) && (default_tap <= depth);
  endfunction

endpackage

// File: rtl/pipe_stage_syncrst.sv
// One data-plus-valid pipeline register; flush clears only the valid flag.
module pipe_stage_syncrst #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  C_ENABLE,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  d_valid,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);

  always_ff @(posedge CLK) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      if (C_ENABLE) q <= d;
      // Flush beats the shift for the valid flag even when enabled.
      if (flush)         q_valid <= 1'b0;
      else if (C_ENABLE) q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/pipe_tap_syncrst.sv
// Delay line of DEPTH register stages with a run-time selectable output tap;
// a fill counter suppresses out_valid until the new tap has been refilled.
module pipe_tap_syncrst
  import dsp_pipe_pkg::*;
#(
  parameter int  DATA_WIDTH  = 18,
  parameter int  DEPTH       = 4,
  parameter int  DEFAULT_TAP = 1,
  localparam int TAP_W       = tap_width(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  C_ENABLE,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [TAP_W-1:0]      tap_sel,
  input  logic                  tap_load,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic [TAP_W-1:0]      tap_cur,
  output logic [TAP_W-1:0]      fill_cnt
);

  localparam logic [TAP_W-1:0] DEPTH_T       = TAP_W'(DEPTH);
  localparam logic [TAP_W-1:0] DEFAULT_TAP_T = TAP_W'(DEFAULT_TAP);

  if (!params_legal(DATA_WIDTH, DEPTH, DEFAULT_TAP)) begin : g_bad_params
    $error("pipe_tap_syncrst: illegal DATA_WIDTH/DEPTH/DEFAULT_TAP");
  end

  logic [DATA_WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]      stage_vld;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [DATA_WIDTH-1:0] d_in;
    logic                  v_in;
    if (gi == 0) begin : g_head
      assign d_in = in;
      assign v_in = in_valid;
    end else begin : g_link
      assign d_in = stage_data[gi-1];
      assign v_in = stage_vld[gi-1];
    end
    pipe_stage_syncrst #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .CLK      (CLK),
      .rst      (rst),
      .C_ENABLE (C_ENABLE),
      .flush    (flush),
      .d        (d_in),
      .d_valid  (v_in),
      .q        (stage_data[gi]),
      .q_valid  (stage_vld[gi])
    );
  end

  logic [TAP_W-1:0] tap_cur_reg, tap_cur_next;
  logic [TAP_W-1:0] fill_cnt_reg, fill_cnt_next;

  // A load restarts the fill count even if C_ENABLE is low or the tap is unchanged.
  always_comb begin
    tap_cur_next  = tap_cur_reg;
    fill_cnt_next = fill_cnt_reg;
    if (tap_load) begin
      tap_cur_next  = (tap_sel > DEPTH_T) ? DEPTH_T : tap_sel;
      fill_cnt_next = '0;
    end else if (C_ENABLE && (fill_cnt_reg != DEPTH_T)) begin
      fill_cnt_next = fill_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      tap_cur_reg  <= DEFAULT_TAP_T;
      fill_cnt_reg <= '0;
    end else begin
      tap_cur_reg  <= tap_cur_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // Tap 0 is a pure combinational bypass of the input.
  always_comb begin
    out       = in;
    out_valid = in_valid;
    for (int k = 1; k <= DEPTH; k++) begin
      if (tap_cur_reg == TAP_W'(k)) begin
        out       = stage_data[k-1];
        out_valid = stage_vld[k-1] && (fill_cnt_reg >= tap_cur_reg);
      end
    end
  end

  assign tap_cur  = tap_cur_reg;
  assign fill_cnt = fill_cnt_reg;

endmodule
